// File: rtl/boot_load_sequencer_if.sv
// Byte stream in, shared imem/dmem write port and CPU control out of the boot loader.
// Stream handshake: a byte moves on a rising clk edge where rx_valid && rx_ready; rx_ready never depends on rx_valid.
interface boot_load_sequencer_if #(
   parameter int ADDR_WIDTH = 14
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  load_req;
   logic                  mem_we;
   logic [3:0]            mem_wbe;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_din;
   logic                  cpu_rst;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      input  rx_data, rx_valid, load_req,
      output rx_ready, mem_we, mem_wbe, mem_addr, mem_din, cpu_rst, busy, done, err
   );

   modport slave (
      output rx_data, rx_valid, load_req,
      input  rx_ready, mem_we, mem_wbe, mem_addr, mem_din, cpu_rst, busy, done, err
   );
endinterface

// File: rtl/boot_load_sequencer.sv
// Loads a framed UART image (SYNC, base, count, words) into imem/dmem, then releases the CPU reset.
module boot_load_sequencer #(
   parameter int          ADDR_WIDTH     = 14,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          RELEASE_CYCLES = 30
) (
   input  logic                      clk,
   input  logic                      rst,
   boot_load_sequencer_if.master     bus,
   output logic [3:0]                state_dbg
);
   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_ADDR, S_LEN, S_DATA, S_WRITE, S_HOLD, S_RUN, S_ERR
   } state_t;

   localparam int          HC_W      = $clog2(RELEASE_CYCLES + 1);
   localparam logic [33:0] MEM_WORDS = 34'd1 << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q;
   logic [31:0]           shift_q;
   logic [ADDR_WIDTH-1:0] base_word_q;
   logic [ADDR_WIDTH:0]   n_q, idx_q, idx_inc;
   logic [HC_W-1:0]       hold_cnt_q;
   logic                  rx_ready_q, cpu_rst_q, busy_q, done_q, err_q;

   logic        accept, kill, last_byte, write_en;
   logic [31:0] asm_word;
   logic [33:0] end_word;

   assign accept    = rx_ready_q & bus.rx_valid;
   assign kill      = bus.load_req & (state_q != S_IDLE);
   assign last_byte = accept & (byte_cnt_q == 2'd3);
   // Bytes arrive little-endian, so each new byte enters at the top and slides down.
   assign asm_word  = {bus.rx_data, shift_q[31:8]};
   assign end_word  = {2'b00, asm_word} + {{(34-ADDR_WIDTH){1'b0}}, base_word_q};
   assign idx_inc   = idx_q + (ADDR_WIDTH+1)'(1);
   assign write_en  = (state_q == S_WRITE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_SYNC;
         S_SYNC:  if (accept && bus.rx_data == SYNC_BYTE) state_d = S_ADDR;
         S_ADDR:  if (last_byte) state_d = (asm_word[1:0] != 2'b00) ? S_ERR : S_LEN;
         S_LEN: begin
            if (last_byte) begin
               if (asm_word == 32'd0)          state_d = S_HOLD;
               else if (end_word > MEM_WORDS)  state_d = S_ERR;
               else                            state_d = S_DATA;
            end
         end
         S_DATA:  if (last_byte) state_d = S_WRITE;
         S_WRITE: state_d = (idx_inc == n_q) ? S_HOLD : S_DATA;
         S_HOLD:  if (hold_cnt_q == HC_W'(RELEASE_CYCLES - 1)) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_ERR:   state_d = S_SYNC;
         default: state_d = S_IDLE;
      endcase
      if (kill) state_d = S_SYNC;
   end

   // Status outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rx_ready_q <= 1'b0;
         cpu_rst_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= state_d inside {S_SYNC, S_ADDR, S_LEN, S_DATA};
         cpu_rst_q  <= (state_d != S_RUN);
         busy_q     <= state_d inside {S_ADDR, S_LEN, S_DATA, S_WRITE, S_HOLD};
         done_q     <= (state_d == S_RUN);
         if (kill || state_d == S_RUN) err_q <= 1'b0;
         else if (state_d == S_ERR)    err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         base_word_q <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         hold_cnt_q  <= '0;
      end else if (kill || state_q == S_SYNC) begin
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         base_word_q <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         hold_cnt_q  <= '0;
      end else begin
         if (accept) begin
            shift_q    <= asm_word;
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end
         if (last_byte && state_q == S_ADDR) base_word_q <= asm_word[ADDR_WIDTH+1:2];
         if (last_byte && state_q == S_LEN)  n_q <= asm_word[ADDR_WIDTH:0];
         if (write_en) idx_q <= idx_inc;
         hold_cnt_q <= (state_q == S_HOLD) ? hold_cnt_q + HC_W'(1) : '0;
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.cpu_rst  = cpu_rst_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.mem_we   = write_en;
   assign bus.mem_wbe  = {4{write_en}};
   assign bus.mem_addr = write_en ? base_word_q + idx_q[ADDR_WIDTH-1:0] : '0;
   assign bus.mem_din  = write_en ? shift_q : '0;
   assign state_dbg    = state_q;
endmodule

// File: tb/tb_boot_load_sequencer.sv
// Randomized frame stimulus for boot_load_sequencer; a scoreboard checks every memory strobe and release timing.
module tb_boot_load_sequencer;
   localparam int         AW        = 14;
   localparam int         RC        = 30;
   localparam logic [7:0] SYNC      = 8'hA5;
   localparam longint     MEM_WORDS = longint'(1) << AW;

   logic       clk;
   logic       rst;
   logic [3:0] state_dbg;
   int         cyc;
   int         last_evt;
   int         n_checks;
   int         n_fail;
   logic [AW+31:0] exp_q[$];
   logic [31:0]    wbuf[8];

   boot_load_sequencer_if #(.ADDR_WIDTH(AW)) bus();

   boot_load_sequencer #(
      .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .RELEASE_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.master), .state_dbg(state_dbg)
   );

   // Clock/reset and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog state=%0d checks=%0d", state_dbg, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every strobe must match the head of the expected queue.
   initial begin
      logic [AW+31:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.rx_valid && bus.rx_ready) last_evt = cyc;
            if (bus.mem_we) begin
               last_evt = cyc;
               check("write_wbe", 64'(bus.mem_wbe), 64'(4'hF));
               check("write_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("write_addr", 64'(bus.mem_addr), 64'(e[AW+31:32]));
                  check("write_data", 64'(bus.mem_din), 64'(e[31:0]));
               end
            end
         end
      end
   end

   // Driver tasks (inputs change 1 time unit after posedge)
   task automatic send_byte(input logic [7:0] b);
      int waited;
      bit acc;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      waited = 0;
      acc = 1'b0;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = bus.rx_ready;
         @(posedge clk); #1;
         waited++;
      end
      bus.rx_valid = 1'b0;
      check("rx_accept", 64'(acc), 64'(1));
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_load();
      bus.load_req = 1'b1;
      @(posedge clk); #1;
      bus.load_req = 1'b0;
   endtask

   task automatic expect_err();
      @(negedge clk);
      check("err_flag", 64'(bus.err), 64'(1));
      check("err_status", 64'({bus.busy, bus.done, bus.cpu_rst}), 64'(3'b001));
      @(posedge clk); #1;
   endtask

   task automatic expect_release();
      int waited;
      waited = 0;
      @(negedge clk);
      while (bus.cpu_rst === 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("release_gap", 64'(cyc - last_evt - 1), 64'(RC));
      check("run_status", 64'({bus.done, bus.busy, bus.err, bus.rx_ready}), 64'(4'b1000));
      @(posedge clk); #1;
   endtask

   // Reference model: decides the frame outcome from the framing rules and queues expected writes.
   task automatic run_frame(input logic [31:0] base, input logic [31:0] n, output bit ok);
      longint word;
      ok = 1'b0;
      send_byte(SYNC);
      send_word(base);
      if (base[1:0] != 2'b00) begin
         expect_err();
         return;
      end
      send_word(n);
      word = longint'(base >> 2) % MEM_WORDS;
      if (n != 0 && word + longint'(n) > MEM_WORDS) begin
         expect_err();
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back({AW'(word + i), wbuf[i]});
         send_word(wbuf[i]);
      end
      expect_release();
      ok = 1'b1;
   endtask

   initial begin
      bit ok;
      logic [31:0] hi, base, n;
      logic [7:0]  g;
      int sel;
      longint word;
      n_checks = 0;
      n_fail   = 0;
      last_evt = 0;
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.load_req = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_status", 64'({bus.cpu_rst, bus.rx_ready, bus.mem_we, bus.mem_wbe, bus.busy, bus.done, bus.err}),
            64'(10'b1000000000));
      check("reset_bus", 64'({bus.mem_addr, bus.mem_din}), 64'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // Reference frame: upper address bits ignored, two words at 0 and 1
      wbuf[0] = 32'h0050_0093;
      wbuf[1] = 32'h00A0_0113;
      run_frame(32'h1000_0000, 32'd2, ok);
      pulse_load();

      // Garbage ahead of the marker, empty image
      send_byte(8'h3C);
      send_byte(8'hFF);
      @(negedge clk);
      check("garbage_not_busy", 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
      run_frame(32'h0000_0100, 32'd0, ok);
      pulse_load();

      // Misaligned base, then a good frame clears err
      run_frame(32'h1000_0002, 32'd1, ok);
      @(negedge clk);
      check("err_sticky", 64'(bus.err), 64'(1));
      @(posedge clk); #1;
      wbuf[0] = $urandom;
      run_frame(32'h0000_0040, 32'd1, ok);
      pulse_load();

      // Top of memory: N=2 overflows, N=1 fits
      run_frame(32'h0000_FFFC, 32'd2, ok);
      wbuf[0] = $urandom;
      run_frame(32'h0000_FFFC, 32'd1, ok);
      pulse_load();

      // load_req after the 3rd byte of the second word
      wbuf[0] = $urandom;
      wbuf[1] = $urandom;
      send_byte(SYNC);
      send_word(32'h0000_0200);
      send_word(32'd2);
      exp_q.push_back({AW'(14'h80), wbuf[0]});
      send_word(wbuf[0]);
      for (int i = 0; i < 3; i++) send_byte(wbuf[1][8*i +: 8]);
      pulse_load();
      @(negedge clk);
      check("abort_status", 64'({bus.cpu_rst, bus.busy, bus.done, bus.err, bus.rx_ready}), 64'(5'b10001));
      check("abort_drained", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
      wbuf[0] = $urandom;
      wbuf[1] = $urandom;
      run_frame(32'h0000_0300, 32'd2, ok);
      pulse_load();

      // Reset in the middle of a data word
      send_byte(SYNC);
      send_word(32'h0000_0400);
      send_word(32'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b0;
      #1;
      check("midreset_status", 64'({bus.cpu_rst, bus.rx_ready, bus.mem_we, bus.mem_wbe, bus.busy, bus.done, bus.err}),
            64'(10'b1000000000));
      check("midreset_bus", 64'({bus.mem_addr, bus.mem_din}), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         g = 8'($urandom_range(0, 255));
         send_byte((g == SYNC) ? 8'h00 : g);
      end
      @(negedge clk);
      check("needs_sync", 64'({bus.busy, bus.rx_ready}), 64'(2'b01));
      @(posedge clk); #1;
      wbuf[0] = $urandom;
      run_frame(32'h0000_0400, 32'd1, ok);
      pulse_load();

      // Randomized frames: near-top bases, misalignment and huge counts mixed in
      for (int k = 0; k < 12; k++) begin
         sel  = $urandom_range(0, 7);
         hi   = $urandom;
         word = (sel < 2) ? MEM_WORDS - longint'($urandom_range(1, 3)) : longint'($urandom_range(0, int'(MEM_WORDS) - 1));
         base = {hi[31:AW+2], AW'(word), 2'b00};
         if (sel == 7) base[1:0] = 2'($urandom_range(1, 3));
         n = (sel == 6) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 4));
         for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
         run_frame(base, n, ok);
         if (ok) pulse_load();
      end

      repeat (4) @(negedge clk);
      check("final_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
